// File: rtl/mole_round_ctrl.sv
// mole_round_ctrl: whack-a-mole game sequencer. Spawns an LFSR-derived mole mask each round,
//   collects hits during a timed window, then strobes the frozen mask/hits pair to the scorer.
// Latency: start -> SPAWN next cycle, first WINDOW cycle after that; a full-timeout round
//   strobes round_done WINDOW_CYCLES+2 cycles after start. No backpressure: the scorer must
//   sample on round_done, and start pulses are ignored while busy.
// Ports:
//   clk, reset         rising-edge clock, synchronous active-low reset
//   start              single-cycle game start (honoured in IDLE and GAMEOVER only)
//   hit_btn            player button levels, one bit per mole
//   led_moles          registered active-mole mask (zero outside SPAWN..SCORE)
//   hit_reg            registered hits captured in the current round
//   round_done         one-cycle strobe, led_moles/hit_reg are final in this cycle
//   round_cnt          rounds completed in the current game
//   busy / game_over   game in progress / game finished
module mole_round_ctrl #(
   parameter int unsigned N_MOLES       = 18,
   parameter int unsigned WINDOW_CYCLES = 1000,
   parameter int unsigned GAP_CYCLES    = 250,
   parameter int unsigned ROUNDS        = 30,
   parameter logic [17:0] SEED          = 18'h00001
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [N_MOLES-1:0] hit_btn,
   output logic [N_MOLES-1:0] led_moles,
   output logic [N_MOLES-1:0] hit_reg,
   output logic               round_done,
   output logic [5:0]         round_cnt,
   output logic               busy,
   output logic               game_over
);

   localparam int unsigned WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
   localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
   localparam logic [5:0]       ROUNDS_C = 6'(ROUNDS);

   typedef enum logic [2:0] {
      S_IDLE, S_SPAWN, S_WINDOW, S_SCORE, S_GAP, S_OVER
   } state_t;

   state_t             state_q, state_d;
   logic [17:0]        lfsr_q, lfsr_d;
   logic [N_MOLES-1:0] led_q, led_d;
   logic [N_MOLES-1:0] hit_q, hit_d;
   logic [WIN_W-1:0]   win_q, win_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic [5:0]         cnt_q, cnt_d;

   logic [17:0]        lfsr_nxt;
   logic [17:0]        mask_raw;
   logic [17:0]        mask18;
   logic [N_MOLES-1:0] hit_acc;
   logic               win_end;
   logic               gap_end;

   // Mask pairs each LFSR bit with the bit 9 places away so roughly a quarter of the
   // moles light; an all-dark pattern would make the round unwinnable, so fall back to mole 0.
   assign lfsr_nxt = {lfsr_q[16:0], lfsr_q[17] ^ lfsr_q[10]};
   assign mask_raw = lfsr_nxt & {lfsr_nxt[8:0], lfsr_nxt[17:9]};
   assign mask18   = (mask_raw == 18'd0) ? 18'd1 : mask_raw;

   // Hits this cycle are folded in before the all-hit test, so the capturing edge
   // and the early exit happen together.
   assign hit_acc = hit_q | (hit_btn & led_q);
   assign win_end = (hit_acc == led_q) || (win_q == WIN_LAST);
   assign gap_end = (gap_q == GAP_LAST);

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start) state_d = S_SPAWN;
         S_SPAWN:  state_d = S_WINDOW;
         S_WINDOW: if (win_end) state_d = S_SCORE;
         S_SCORE:  state_d = S_GAP;
         S_GAP:    if (gap_end) state_d = (cnt_q == ROUNDS_C) ? S_OVER : S_SPAWN;
         S_OVER:   if (start) state_d = S_SPAWN;
         default:  state_d = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      round_done = 1'b0;
      busy       = 1'b0;
      game_over  = 1'b0;
      case (state_q)
         S_SPAWN, S_WINDOW, S_GAP: busy = 1'b1;
         S_SCORE: begin
            busy       = 1'b1;
            round_done = 1'b1;
         end
         S_OVER:  game_over = 1'b1;
         default: ;
      endcase
   end

   // Datapath next-state
   always_comb begin
      lfsr_d = lfsr_q;
      led_d  = led_q;
      hit_d  = hit_q;
      win_d  = win_q;
      gap_d  = gap_q;
      cnt_d  = cnt_q;
      case (state_q)
         S_SPAWN: begin
            lfsr_d = lfsr_nxt;
            led_d  = N_MOLES'(mask18);
            hit_d  = '0;
            win_d  = '0;
         end
         S_WINDOW: begin
            hit_d = hit_acc;
            win_d = win_q + 1'b1;
         end
         S_SCORE: begin
            // led/hit stay frozen through this cycle; they go dark for the gap
            cnt_d = cnt_q + 6'd1;
            led_d = '0;
            hit_d = '0;
            gap_d = '0;
         end
         S_GAP: gap_d = gap_q + 1'b1;
         // Restart keeps the LFSR running so consecutive games differ
         S_OVER: if (start) cnt_d = 6'd0;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         lfsr_q <= SEED;
         led_q  <= '0;
         hit_q  <= '0;
         win_q  <= '0;
         gap_q  <= '0;
         cnt_q  <= '0;
      end else begin
         lfsr_q <= lfsr_d;
         led_q  <= led_d;
         hit_q  <= hit_d;
         win_q  <= win_d;
         gap_q  <= gap_d;
         cnt_q  <= cnt_d;
      end
   end

   assign led_moles = led_q;
   assign hit_reg   = hit_q;
   assign round_cnt = cnt_q;

endmodule

// File: tb/tb_mole_round_ctrl.sv
module tb_mole_round_ctrl;

   localparam int          N    = 18;
   localparam int          W    = 8;
   localparam int          G    = 2;
   localparam int          R    = 3;
   localparam logic [17:0] SEED = 18'h00001;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [N-1:0] hit_btn;
   logic [N-1:0] led_moles;
   logic [N-1:0] hit_reg;
   logic         round_done;
   logic [5:0]   round_cnt;
   logic         busy;
   logic         game_over;

   always #5 clk = ~clk;

   mole_round_ctrl #(
      .N_MOLES(N), .WINDOW_CYCLES(W), .GAP_CYCLES(G), .ROUNDS(R), .SEED(SEED)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .hit_btn(hit_btn),
      .led_moles(led_moles), .hit_reg(hit_reg), .round_done(round_done),
      .round_cnt(round_cnt), .busy(busy), .game_over(game_over)
   );

   typedef struct {
      logic [17:0] mask;
      logic [17:0] hit;
      int          rnd;
      int          at;
   } exp_t;

   exp_t        sbq[$];
   int          n_chk = 0;
   int          n_pass = 0;
   int          cyc = 0;
   bit          prev_rd = 1'b0;
   logic [17:0] m_lfsr;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference model: game rules expressed directly on values.
   function automatic logic [17:0] lfsr_step(input logic [17:0] s);
      return {s[16:0], s[17] ^ s[10]};
   endfunction

   function automatic logic [17:0] mole_mask(input logic [17:0] n);
      logic [17:0] m;
      m = n & {n[8:0], n[17:9]};
      return (m == 18'd0) ? 18'd1 : m;
   endfunction

   // Monitor: every strobe must match the oldest pending round.
   always @(negedge clk) begin
      exp_t e;
      if (reset === 1'b1 && round_done === 1'b1) begin
         check("rd_not_back_to_back", 32'(prev_rd), 32'd0);
         if (sbq.size() == 0) begin
            n_chk++;
            $display("FAIL rd_unexpected: strobe at cycle %0d, expected none", cyc);
         end else begin
            e = sbq.pop_front();
            check("score_led", 32'(led_moles), 32'(e.mask));
            check("score_hit", 32'(hit_reg), 32'(e.hit));
            check("score_round_cnt", 32'(round_cnt), 32'(e.rnd));
            check("score_cycle", 32'(cyc), 32'(e.at));
            check("score_flags", {30'd0, busy, game_over}, 32'd2);
         end
      end
      prev_rd = (round_done === 1'b1);
   end

   // One game from IDLE/GAMEOVER. With try_reset, the first round whose mask has
   // two or more moles gets one hit then a mid-window reset.
   task automatic play_game(input int g, input bit try_reset, output bit did_reset);
      logic [17:0] b[W];
      logic [17:0] mask, acc, low;
      int          mode, k;
      did_reset = 1'b0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      check("spawn_flags", {30'd0, busy, game_over}, 32'd2);
      check("spawn_round_cnt", 32'(round_cnt), 32'd0);
      for (int r = 0; r < R; r++) begin
         m_lfsr = lfsr_step(m_lfsr);
         mask   = mole_mask(m_lfsr);
         if (try_reset && $countones(mask) >= 2) begin
            low = mask & (~mask + 18'd1);
            @(negedge clk) hit_btn = low;
            @(negedge clk);
            check("rst_pre_hit", 32'(hit_reg), 32'(low));
            check("rst_pre_led", 32'(led_moles), 32'(mask));
            reset   = 1'b0;
            hit_btn = '0;
            @(negedge clk);
            check("rst_led", 32'(led_moles), 32'd0);
            check("rst_hit", 32'(hit_reg), 32'd0);
            check("rst_flags", {23'd0, round_done, round_cnt, busy, game_over}, 32'd0);
            reset     = 1'b1;
            m_lfsr    = SEED;
            did_reset = 1'b1;
            return;
         end
         if (g == 0)      mode = (r == 0) ? 3 : (r == 1) ? 2 : 4;
         else if (g == 1) mode = (r == 0) ? 0 : (r == 1) ? 5 : 1;
         else             mode = $urandom_range(0, 5);
         for (int i = 0; i < W; i++) begin
            case (mode)
               0:       b[i] = 18'd0;
               1:       b[i] = 18'($urandom & $urandom);
               2:       b[i] = (i == W - 1) ? 18'h3FFFF : 18'd0;
               3:       b[i] = mask;
               4:       b[i] = ~mask;
               default: b[i] = 18'd1 << $urandom_range(0, 17);
            endcase
         end
         acc = '0;
         k   = W - 1;
         for (int i = 0; i < W; i++) begin
            acc = acc | (b[i] & mask);
            if (acc == mask) begin
               k = i;
               break;
            end
         end
         for (int i = 0; i <= k; i++) begin
            @(negedge clk);
            hit_btn = b[i];
            start   = (r == 1 && i == 0);
         end
         sbq.push_back('{mask, acc, r, cyc + 1});
         @(negedge clk);
         hit_btn = '0;
         start   = 1'b0;
         @(negedge clk);
         check("gap_led", 32'(led_moles), 32'd0);
         check("gap_hit", 32'(hit_reg), 32'd0);
         check("gap_round_cnt", 32'(round_cnt), 32'(r + 1));
         check("gap_busy", 32'(busy), 32'd1);
         repeat (G - 1) @(negedge clk);
         if (r < R - 1) @(negedge clk);
      end
      @(negedge clk);
      check("over_flags", {30'd0, busy, game_over}, 32'd1);
      check("over_round_cnt", 32'(round_cnt), 32'(R));
      check("over_led", 32'(led_moles), 32'd0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
   endtask

   initial begin
      bit dr, found;
      reset   = 1'b0;
      start   = 1'b0;
      hit_btn = '0;
      m_lfsr  = SEED;
      repeat (3) @(negedge clk);
      check("reset_led", 32'(led_moles), 32'd0);
      check("reset_hit", 32'(hit_reg), 32'd0);
      check("reset_flags", {23'd0, round_done, round_cnt, busy, game_over}, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      check("idle_flags", {23'd0, round_done, round_cnt, busy, game_over}, 32'd0);

      for (int g = 0; g < 20; g++) play_game(g, 1'b0, dr);

      found = 1'b0;
      for (int t = 0; t < 30 && !found; t++) play_game(2, 1'b1, found);
      check("reset_round_found", 32'(found), 32'd1);
      if (found) play_game(0, 1'b0, dr);

      repeat (3) @(negedge clk);
      check("sb_drain", 32'(sbq.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mole_round_ctrl.md
Name: mole_round_ctrl

Overview:
- Game sequencer for the whack-a-mole datapath.
- Runs a fixed number of rounds. Each round it spawns a pseudo-random mole pattern on `led_moles`, then accumulates player hits into `hit_reg` during a timed window.
- At the end of each round it presents the frozen `led_moles`/`hit_reg` pair with a one-cycle `round_done` strobe, which the downstream scorer samples.
- Owns game start/stop, round counting and the inter-round gap.

Parameters:
- N_MOLES, 18, number of mole LEDs/buttons; all mask ports are N_MOLES wide.
- WINDOW_CYCLES, 1000, length of the hit window in clk cycles; must be ≥2.
- GAP_CYCLES, 250, dark cycles between rounds; must be ≥1.
- ROUNDS, 30, rounds per game; range 1..63.
- SEED, 18'h00001, LFSR reset value; must be nonzero.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  single-cycle start pulse, already synchronised.
- hit_btn  input  N_MOLES  player button levels, already synchronised and debounced.
- led_moles  output  N_MOLES  active mole mask, registered.
- hit_reg  output  N_MOLES  hits accumulated this round, registered.
- round_done  output  1  one-cycle strobe; `led_moles`/`hit_reg` are valid for scoring in this cycle.
- round_cnt  output  6  completed rounds in the current game.
- busy  output  1  high in SPAWN, WINDOW, SCORE and GAP.
- game_over  output  1  high in GAMEOVER.

Behaviour:
- Reset (reset==0 at a clk edge), on any state including mid-round:
  - state=IDLE, led_moles=0, hit_reg=0, round_done=0, round_cnt=0, busy=0, game_over=0.
  - lfsr=SEED; window and gap counters=0.
- LFSR: 18-bit Fibonacci, next = {lfsr[16:0], lfsr[17]^lfsr[10]}. It advances only in SPAWN.
- Mole mask: m = nxt & {nxt[8:0], nxt[17:9]}, where nxt is the advanced LFSR value. If m==0, use 18'h00001.
- IDLE: all outputs low. start → SPAWN.
- SPAWN (1 cycle):
  - lfsr ← nxt; led_moles ← mask(nxt); hit_reg ← 0; window counter ← 0.
  - → WINDOW.
- WINDOW:
  - Each cycle: hit_reg ← hit_reg | (hit_btn & led_moles). Buttons on unlit moles are ignored.
  - Counter increments every cycle.
  - Early exit: if (hit_reg | (hit_btn & led_moles)) == led_moles, → SCORE next cycle; the capturing update is included.
  - Timeout: the counter reaching WINDOW_CYCLES-1 → SCORE. Hits in that last cycle are captured.
  - Early exit and timeout in the same cycle behave identically: → SCORE.
- SCORE (1 cycle):
  - round_done=1; led_moles and hit_reg hold their final values.
  - round_cnt ← round_cnt+1 at the end of the cycle.
  - → GAP.
- GAP:
  - led_moles=0, hit_reg=0; counts GAP_CYCLES cycles.
  - Exit: → GAMEOVER if round_cnt==ROUNDS, else → SPAWN.
- GAMEOVER:
  - game_over=1; round_cnt holds its final value; led_moles=0.
  - start → SPAWN. On the same edge, round_cnt ← 0 and the LFSR is not reseeded, so the sequence continues.
- start while busy is ignored, with no restart or counter effect.
- Round latency: start at edge t.
  - t+1: SPAWN.
  - t+2: first WINDOW cycle, with led_moles valid.
  - Full timeout round: round_done asserts at t+2+WINDOW_CYCLES.
- round_done is never asserted in two consecutive cycles. Exactly ROUNDS strobes occur per game.

Test Plan:
- Reset → all outputs 0. Pulse start → led_moles=18'h00001 in the 2nd cycle after start; busy=1.
- Round 1 with hit_btn=18'h00001 held from the first WINDOW cycle → SCORE on the next cycle; round_done=1 with hit_reg=18'h00001; round_cnt=1 afterwards.
- WINDOW_CYCLES=8, hit_btn=0 throughout → round_done exactly 10 cycles after start, hit_reg=0. hit_btn=all-ones for only the last window cycle → hit_reg==led_moles at SCORE.
- Buttons on unlit moles, e.g. hit_btn=18'h3FFFE while led_moles=18'h00001 → hit_reg stays 0; the round ends by timeout.
- ROUNDS=3, GAP_CYCLES=2, no hits → exactly 3 round_done strobes, then game_over=1 and round_cnt=3. A start pulse during that game has no effect. start in GAMEOVER → round_cnt=0 and a new round begins.
- Assert reset mid-WINDOW with hit_reg≠0 → next cycle: IDLE, all outputs 0, lfsr=SEED. A following start reproduces the first-round mask 18'h00001.
